// File: rtl/ic74148_pkg.sv
// Shared sizing and FSM state type for the 8-line registered interrupt priority encoder.
package ic74148_pkg;

  localparam int N_LINES = 8;
  localparam int CODE_W  = $clog2(N_LINES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

endpackage

// File: rtl/ic74148_prio_enc.sv
// Purpose: combinational N-to-log2(N) priority encoder, highest index wins.
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows elig directly.
module ic74148_prio_enc
  import ic74148_pkg::*;
(
  input  logic [N_LINES-1:0] elig,
  output logic [CODE_W-1:0]  code,
  output logic               any
);

  // Ascending scan: a later (higher) set index overwrites any lower one.
  always_comb begin
    code = '0;
    any  = 1'b0;
    for (int k = 0; k < N_LINES; k++) begin
      if (elig[k]) begin
        code = CODE_W'(k);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ic74148_irq_encoder.sv
// Purpose: latch falling-edge requests and present the highest-priority unmasked one as a code.
// Latency: request sampled low at edge N is pending at N; valid_o rises after edge N+1 from IDLE.
// Backpressure: code held stable until ack_i, then one HOLDOFF cycle before the next presentation.
module ic74148_irq_encoder
  import ic74148_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ei_n_i,
  input  logic [N_LINES-1:0] req_n_i,
  input  logic [N_LINES-1:0] mask_i,
  input  logic               ack_i,
  output logic [CODE_W-1:0]  code_o,
  output logic               valid_o,
  output logic               gs_n_o,
  output logic               eo_n_o
);

  state_e              state_q, state_d;
  logic [N_LINES-1:0]  pending_q, pending_d;
  logic [N_LINES-1:0]  req_prev_q;
  logic [N_LINES-1:0]  rise, elig, clr;
  logic [CODE_W-1:0]   pick, code_d;
  logic                any_elig, valid_d;

  assign rise = req_prev_q & ~req_n_i;
  assign elig = pending_q & ~mask_i;

  ic74148_prio_enc u_prio_enc (
    .elig (elig),
    .code (pick),
    .any  (any_elig)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_o;
    valid_d = valid_o;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (!ei_n_i && any_elig) begin
          code_d  = pick;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ack_i) begin
          clr[code_o] = 1'b1;
          valid_d     = 1'b0;
          state_d     = HOLDOFF;
        end
      end
      HOLDOFF: state_d = IDLE;
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Set after clear: a fresh edge on the line being acked keeps it pending.
  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      req_prev_q <= '1;
      code_o     <= '0;
      valid_o    <= 1'b0;
      gs_n_o     <= 1'b1;
      eo_n_o     <= 1'b1;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      req_prev_q <= req_n_i;
      code_o     <= code_d;
      valid_o    <= valid_d;
      gs_n_o     <= ei_n_i | ~any_elig;
      eo_n_o     <= ei_n_i | any_elig;
    end
  end

endmodule

// File: tb/tb_ic74148_irq_encoder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_ic74148_irq_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ei_n = 1'b0;
  logic [7:0] req_n = 8'hFF;
  logic [7:0] mask = 8'h00;
  logic       ack = 1'b0;
  logic [2:0] code;
  logic       valid, gs_n, eo_n;

  int checks = 0;
  int errors = 0;

  ic74148_irq_encoder dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .ei_n_i  (ei_n),
    .req_n_i (req_n),
    .mask_i  (mask),
    .ack_i   (ack),
    .code_o  (code),
    .valid_o (valid),
    .gs_n_o  (gs_n),
    .eo_n_o  (eo_n)
  );

  always #5 clk = ~clk;

  // Behavioural reference: pending set as a bit array, presentation tracked as busy/holdoff flags.
  bit [7:0] m_pend = '0;
  bit [7:0] m_prev = '1;
  bit       m_busy = 1'b0;
  bit       m_hold = 1'b0;
  int       m_code = 0;
  bit       m_gs = 1'b1;
  bit       m_eo = 1'b1;

  always @(posedge clk or posedge rst) begin
    int       best;
    bit [7:0] nxt;
    if (rst) begin
      m_pend = '0; m_prev = '1; m_busy = 0; m_hold = 0;
      m_code = 0;  m_gs = 1;    m_eo = 1;
    end else begin
      best = -1;
      for (int k = 0; k < 8; k++)
        if (m_pend[k] && !mask[k]) best = k;
      nxt = m_pend;
      if (m_busy) begin
        if (ack) begin
          nxt[m_code] = 1'b0;
          m_busy = 0;
          m_hold = 1;
        end
      end else if (m_hold) begin
        m_hold = 0;
      end else if (!ei_n && best >= 0) begin
        m_code = best;
        m_busy = 1;
      end
      for (int k = 0; k < 8; k++)
        if (m_prev[k] && !req_n[k]) nxt[k] = 1'b1;
      m_gs   = ei_n || (best < 0);
      m_eo   = ei_n || (best >= 0);
      m_pend = nxt;
      m_prev = req_n;
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (code !== 3'd0)  begin errors++; $display("FAIL reset_code got %0d want 0", code); end
    checks++; if (gs_n !== 1'b1)  begin errors++; $display("FAIL reset_gs got %b want 1", gs_n); end
    checks++; if (eo_n !== 1'b1)  begin errors++; $display("FAIL reset_eo got %b want 1", eo_n); end
    @(negedge clk);
    ei_n = 1'b0; req_n = 8'hFF; rst = 1'b0;
    @(negedge clk);
    checks++; if (eo_n !== 1'b0) begin errors++; $display("FAIL idle_eo got %b want 0", eo_n); end
    checks++; if (gs_n !== 1'b1) begin errors++; $display("FAIL idle_gs got %b want 1", gs_n); end
  endtask

  task automatic test_single();
    req_n = 8'b1111_1011;
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", valid); end
    @(negedge clk);
    checks++; if (valid !== 1'b1 || code !== 3'd2 || gs_n !== 1'b0)
      begin errors++; $display("FAIL single_present got v=%b c=%0d gs=%b want v=1 c=2 gs=0", valid, code, gs_n); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_no_repeat cyc %0d got %b want 0", i, valid); end
      @(negedge clk);
    end
    req_n = 8'hFF;
    @(negedge clk);
  endtask

  task automatic test_priority();
    req_n = 8'b0111_1110;
    repeat (2) @(negedge clk);
    checks++; if (valid !== 1'b1 || code !== 3'd7)
      begin errors++; $display("FAIL prio_first got v=%b c=%0d want v=1 c=7", valid, code); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL prio_holdoff got %b want 0", valid); end
    repeat (2) @(negedge clk);
    checks++; if (valid !== 1'b1 || code !== 3'd0)
      begin errors++; $display("FAIL prio_second got v=%b c=%0d want v=1 c=0", valid, code); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    checks++; if (eo_n !== 1'b0) begin errors++; $display("FAIL prio_eo got %b want 0", eo_n); end
    req_n = 8'hFF;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mask();
    mask = 8'h80; req_n = 8'b0111_1110;
    repeat (2) @(negedge clk);
    checks++; if (valid !== 1'b1 || code !== 3'd0)
      begin errors++; $display("FAIL mask_low got v=%b c=%0d want v=1 c=0", valid, code); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; mask = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (valid !== 1'b1 || code !== 3'd7)
      begin errors++; $display("FAIL mask_retained got v=%b c=%0d want v=1 c=7", valid, code); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; req_n = 8'hFF;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_enable();
    ei_n = 1'b1; req_n = 8'b1101_1111;
    repeat (3) @(negedge clk);
    checks++; if (valid !== 1'b0 || gs_n !== 1'b1 || eo_n !== 1'b1)
      begin errors++; $display("FAIL ei_block got v=%b gs=%b eo=%b want 0 1 1", valid, gs_n, eo_n); end
    ei_n = 1'b0;
    @(negedge clk);
    checks++; if (valid !== 1'b1 || code !== 3'd5)
      begin errors++; $display("FAIL ei_release got v=%b c=%0d want v=1 c=5", valid, code); end
    ei_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (valid !== 1'b1 || code !== 3'd5)
      begin errors++; $display("FAIL ei_hold got v=%b c=%0d want v=1 c=5", valid, code); end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0; ei_n = 1'b0; req_n = 8'hFF;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_collision();
    req_n = 8'b1110_1111;
    repeat (2) @(negedge clk);
    checks++; if (valid !== 1'b1 || code !== 3'd4)
      begin errors++; $display("FAIL coll_first got v=%b c=%0d want v=1 c=4", valid, code); end
    req_n = 8'hFF;
    @(negedge clk);
    ack = 1'b1; req_n = 8'b1110_1111;
    @(negedge clk);
    ack = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL coll_holdoff got %b want 0", valid); end
    repeat (2) @(negedge clk);
    checks++; if (valid !== 1'b1 || code !== 3'd4)
      begin errors++; $display("FAIL coll_repeat got v=%b c=%0d want v=1 c=4", valid, code); end
    #2 rst = 1'b1;
    #1;
    checks++; if (valid !== 1'b0 || code !== 3'd0)
      begin errors++; $display("FAIL rst_present got v=%b c=%0d want v=0 c=0", valid, code); end
    @(negedge clk);
    req_n = 8'hFF; rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (valid !== 1'b0 || eo_n !== 1'b0)
      begin errors++; $display("FAIL rst_pending got v=%b eo=%b want v=0 eo=0", valid, eo_n); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      checks++;
      if (valid !== m_busy || (m_busy && code !== 3'(m_code)) || gs_n !== m_gs || eo_n !== m_eo) begin
        errors++;
        $display("FAIL random cyc %0d got v=%b c=%0d gs=%b eo=%b want v=%b c=%0d gs=%b eo=%b",
                 i, valid, code, gs_n, eo_n, m_busy, m_code, m_gs, m_eo);
      end
      req_n = req_n ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 15) == 0) mask = 8'($urandom) & 8'($urandom);
      ei_n = ($urandom_range(0, 9) == 0);
      ack  = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_enable();
    test_collision();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ic74148_irq_encoder.md
Name: ic74148_irq_encoder

Overview:
- Registered 8-line priority encoder: the encode-side counterpart of the ic74138 3-to-8 decoder, with 74148-style EI/GS/EO semantics.
- Latches falling-edge requests on active-low request lines and presents the highest-priority unmasked pending line as a 3-bit code.
- Uses a valid/ack handshake to a consumer, typically an interrupt-service sequencer or a 74138 select driver.
- Line 7 has the highest priority, line 0 the lowest.

Parameters:
- N_LINES, 8, number of request lines; fixed at 8 in this revision, must be a power of 2.
- CODE_W, 3, code width, equal to $clog2(N_LINES).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- ei_n_i  in  1  enable input, active-low (74148 EI)
- req_n_i  in  8  request lines, active-low, synchronous to clk_i
- mask_i  in  8  per-line mask; 1 = line ignored for presentation
- ack_i  in  1  consumer acknowledge of the presented code
- code_o  out  3  index of presented line, active-high binary
- valid_o  out  1  code_o holds a presented request
- gs_n_o  out  1  group select, active-low, registered
- eo_n_o  out  1  enable output, active-low, registered (cascade to lower-priority stage)

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, pending=0, req_prev=8'hFF.
  - code_o=0, valid_o=0, gs_n_o=1, eo_n_o=1.
  - Outputs change immediately, without waiting for a clock edge; reset mid-handshake drops valid_o at once.
- Edge capture, every cycle:
  - rise_k = req_prev[k] & ~req_n_i[k]; pending[k] is set on that edge.
  - req_prev <= req_n_i.
  - A level held low does not re-set a bit once it is cleared.
- Eligible set: elig = pending & ~mask_i. Priority pick: highest set index of elig, plus any_elig.
- FSM states IDLE, PRESENT, HOLDOFF:
  - IDLE: if ei_n_i=0 and any_elig, then code_o<=pick, valid_o<=1, go to PRESENT. Otherwise stay.
  - PRESENT: code_o and valid_o stay stable regardless of mask_i/ei_n_i/req changes. On ack_i=1: clear pending[code_o], valid_o<=0, go to HOLDOFF.
  - HOLDOFF: valid_o=0 for exactly 1 cycle, then IDLE. This guarantees at least one deasserted cycle between presentations.
- Latency: req_n_i first sampled low at edge N sets pending at edge N. From IDLE, valid_o=1 after edge N+1.
- Simultaneous ack and new rise on the same line: set wins, so pending stays 1 and the line is presented again after HOLDOFF.
- ack_i outside PRESENT is ignored.
- gs_n_o/eo_n_o, registered each cycle:
  - ei_n_i=1: gs_n_o=1, eo_n_o=1.
  - ei_n_i=0 and any_elig: gs_n_o=0, eo_n_o=1.
  - ei_n_i=0 and no elig: gs_n_o=1, eo_n_o=0.
- ei_n_i=1 blocks new presentations only; pending bits are still captured, and an already-presented code stays until acked.
- Masking does not clear pending; unmasking a pending line makes it eligible in the next IDLE evaluation.

Decomposition:
- Package ic74148_pkg holds N_LINES, CODE_W, and the state enum state_e {IDLE, PRESENT, HOLDOFF}.
- Sub-module ic74148_prio_enc: combinational 8-to-3 priority encoder.
  - Inputs: elig[7:0].
  - Outputs: code[2:0], any.
  - Priority order: 7 highest.
  - Unit-testable standalone.

Test Plan:
1. Reset and idle:
   - Drive rst_i=1 mid-cycle -> valid_o=0, code_o=0, gs_n_o=1, eo_n_o=1 immediately.
   - Release with ei_n_i=0, req_n_i=8'hFF -> eo_n_o=0, gs_n_o=1 after 1 edge.
2. Single request:
   - req_n_i 8'hFF -> 8'b1111_1011, held low -> valid_o=1, code_o=2 after the 2nd edge, gs_n_o=0.
   - ack_i pulse -> valid_o=0, one HOLDOFF cycle, no re-presentation although line 2 stays low.
3. Priority:
   - Lines 7 and 0 fall in the same cycle (req_n_i=8'b0111_1110) -> code_o=7 first.
   - ack -> after HOLDOFF, code_o=0, valid_o=1.
   - ack -> eo_n_o=0.
4. Mask:
   - mask_i=8'h80, lines 7 and 0 fall -> only code_o=0 is presented.
   - ack, then mask_i=8'h00 -> code_o=7 presented from the retained pending bit.
5. Enable:
   - ei_n_i=1, line 5 falls -> valid_o stays 0, gs_n_o=1, eo_n_o=1.
   - ei_n_i=0 -> code_o=5, valid_o=1 next edge.
   - ei_n_i=1 while PRESENT -> code_o=5 is held until ack.
6. Collision and reset:
   - While code_o=4 is presented, ack_i and a new fall on line 4 occur in the same cycle -> code 4 is re-presented after HOLDOFF.
   - Assert rst_i while PRESENT -> valid_o=0 and pending=0 asynchronously.
